rx_uart_deser: RTL

- Serial receive deserializer that sits directly downstream of the receiver power-up controller.
- Stays disarmed until that controller's RDY_RX is high, then converts the asynchronous line RX_IN into bytes.
- Frame format: 1 start bit (low), DATA_BITS data bits LSB first, 1 stop bit (high), idle high.
- Each good byte is presented with a one-cycle valid strobe; a bad stop bit gives a one-cycle error strobe instead.

---
 rtl/rx_pkg.sv | 17 +
 rtl/rx_sync2.sv | 25 ++
 rtl/rx_uart_deser.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/rx_pkg.sv
// Shared definitions for the receive deserializer slice: state encoding and
// default frame geometry.
package rx_pkg;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_ARM   = 3'd1,
    S_IDLE  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } rx_state_e;

  localparam int unsigned CLKS_PER_BIT_DEF = 16;
  localparam int unsigned DATA_BITS_DEF    = 8;

endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchronizer for asynchronous receive-side inputs; resets to the
// line idle level (1).
module rx_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rx_uart_deser.sv
// UART receive deserializer: arms after receiver power-up, then frames
// start/data/stop bits into bytes with one-cycle valid or error strobes.
module rx_uart_deser #(
  parameter int unsigned CLKS_PER_BIT = rx_pkg::CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_BITS    = rx_pkg::DATA_BITS_DEF
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 RDY_RX,
  input  logic                 RX_IN,
  output logic [DATA_BITS-1:0] DATA_OUT,
  output logic                 DATA_VALID,
  output logic                 FRAME_ERR,
  output logic                 BUSY
);

  import rx_pkg::*;

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  rx_sync2 u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (RX_IN),
    .q     (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic                 brk_q, brk_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
      brk_q   <= brk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    brk_d   = brk_q;

    unique case (state_q)
      S_OFF: begin
        if (RDY_RX) begin
          state_d = S_ARM;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_ARM: begin
        if (!rx_s) begin
          cnt_d = '0;
        end else if (cnt_q == FULL_M1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
        // After a break the line must be seen high before a new start counts.
        if (rx_s) begin
          brk_d = 1'b0;
        end else if (!brk_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s) begin
            data_d  = sh_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
            brk_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_OFF;
    endcase

    // Power loss overrides everything, including a strobe due on this edge.
    if (!RDY_RX) begin
      state_d = S_OFF;
      cnt_d   = '0;
      bit_d   = '0;
      brk_d   = 1'b0;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
    end

    busy_d = state_d inside {S_START, S_DATA, S_STOP};
  end

  assign DATA_OUT   = data_q;
  assign DATA_VALID = valid_q;
  assign FRAME_ERR  = ferr_q;
  assign BUSY       = busy_q;

endmodule
